// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the 32-bit register bus between the uP packet handler (0) and an internal sequencer (1).
// Optional grant statistics at address 8'hFF are built when REG_BUS_ARB_STATS_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a request, grants round-robin
// ISSUE    | one-cycle read/write strobe, or straight to RESPOND for illegal/local ops
// WAIT_ACK | waiting for target ack, bounded by TIMEOUT_CYCLES
// RESPOND  | rsp_valid held for the winner until rsp_ready
module reg_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [15:0]         req_cmd,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [63:0]         req_wdata,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [31:0]         rsp_data,
    output logic [31:0]         rsp_status,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [31:0]         bus_wdata,
    output logic                bus_write,
    output logic                bus_read,
    input  logic [31:0]         bus_rdata,
    input  logic                bus_ack,
    output logic                grant_id
);
    localparam logic [7:0]  CMD_READ  = 8'h00;
    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESPOND} state_t;

    state_t              state;
    logic                last_grant;
    logic [7:0]          lat_cmd;
    logic                lat_illegal;
    logic                lat_stats;
    logic [15:0]         to_cnt;

    logic                gnt_any;
    logic                gnt_sel;
    logic [7:0]          sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_illegal;
    logic                stats_hit;
    logic [31:0]         stats_word;

    always_comb begin
        gnt_any     = |req_valid;
        gnt_sel     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        sel_cmd     = gnt_sel ? req_cmd[15:8] : req_cmd[7:0];
        sel_addr    = gnt_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata   = gnt_sel ? req_wdata[63:32] : req_wdata[31:0];
        sel_illegal = (sel_cmd != CMD_READ) && (sel_cmd != CMD_WRITE);
    end

    // bus_addr doubles as the latched request address for the echo field
    function automatic logic [31:0] status_word(input logic timeout, input logic illegal);
        return {8'h00, lat_cmd, 8'(bus_addr), 5'b00000, grant_id, illegal, timeout};
    endfunction

`ifdef REG_BUS_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;

    assign stats_hit = (sel_addr == ADDR_W'(8'hFF));

    // Snapshot is taken before this grant is counted, so a stats read reports prior grants
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= 16'h0000;
            grant_cnt1 <= 16'h0000;
            stats_word <= 32'h0;
        end else if (state == IDLE && gnt_any) begin
            stats_word <= {grant_cnt1, grant_cnt0};
            if (stats_hit && sel_cmd == CMD_WRITE) begin
                grant_cnt0 <= 16'h0000;
                grant_cnt1 <= 16'h0000;
            end else if (gnt_sel) begin
                if (grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
            end else begin
                if (grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            end
        end
    end
`else
    assign stats_hit  = 1'b0;
    assign stats_word = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            req_ready   <= 2'b00;
            rsp_valid   <= 2'b00;
            rsp_data    <= 32'h0;
            rsp_status  <= 32'h0;
            bus_addr    <= '0;
            bus_wdata   <= 32'h0;
            bus_write   <= 1'b0;
            bus_read    <= 1'b0;
            lat_cmd     <= 8'h00;
            lat_illegal <= 1'b0;
            lat_stats   <= 1'b0;
            to_cnt      <= 16'h0000;
        end else begin
            req_ready <= 2'b00;
            bus_write <= 1'b0;
            bus_read  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state       <= ISSUE;
                        req_ready   <= gnt_sel ? 2'b10 : 2'b01;
                        last_grant  <= gnt_sel;
                        grant_id    <= gnt_sel;
                        lat_cmd     <= sel_cmd;
                        bus_addr    <= sel_addr;
                        bus_wdata   <= sel_wdata;
                        lat_illegal <= sel_illegal;
                        lat_stats   <= stats_hit && !sel_illegal;
                        to_cnt      <= 16'h0000;
                        bus_write   <= (sel_cmd == CMD_WRITE) && !stats_hit;
                        bus_read    <= (sel_cmd == CMD_READ) && !stats_hit;
                    end
                end
                ISSUE: begin
                    if (lat_illegal || lat_stats) begin
                        state      <= RESPOND;
                        rsp_valid  <= grant_id ? 2'b10 : 2'b01;
                        rsp_data   <= (lat_stats && lat_cmd == CMD_READ) ? stats_word : 32'h0;
                        rsp_status <= status_word(1'b0, lat_illegal);
                    end else begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus_ack) begin
                        state      <= RESPOND;
                        rsp_valid  <= grant_id ? 2'b10 : 2'b01;
                        rsp_data   <= (lat_cmd == CMD_READ) ? bus_rdata : 32'h0;
                        rsp_status <= status_word(1'b0, 1'b0);
                    end else if (to_cnt == TO_LAST) begin
                        state      <= RESPOND;
                        rsp_valid  <= grant_id ? 2'b10 : 2'b01;
                        rsp_data   <= 32'h0;
                        rsp_status <= status_word(1'b1, 1'b0);
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: stimulus pushes expected bus cycles and responses, monitor pops and compares.
`timescale 1ns/1ps
module tb_reg_bus_arbiter;
    localparam int TO = 10;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [15:0]   req_cmd;
    logic [2*AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [31:0]   rsp_data;
    logic [31:0]   rsp_status;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_write;
    logic          bus_read;
    logic [31:0]   bus_rdata;
    logic          bus_ack;
    logic          grant_id;

    reg_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct { int g; logic [31:0] data; logic [31:0] status; int lat; } rsp_exp_t;
    typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; } bus_exp_t;

    rsp_exp_t rsp_q[$];
    bus_exp_t bus_q[$];
    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         ack_delay = -1;
    logic [31:0] tgt_rdata = 32'h0;
    int         tgt_cnt = -1;
    int         late_ack_cnt = 0;
    int         late_seen = 0;
    int         rst_cnt = 0;
    int         rst_seen = 0;
    int         rsp_delay = 0;
    int         rdy_cyc[2];
    logic       strobe_open = 1'b0;

    logic [7:0]  p_cmd[2][2];
    logic [7:0]  p_addr[2][2];
    logic [31:0] p_wd[2][2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_bus(input logic wr, input logic [7:0] a, input logic [31:0] wd);
        bus_exp_t b;
        b.wr = wr; b.addr = a; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic expect_rsp(input int g, input logic [31:0] d, input logic [31:0] s, input int lat);
        rsp_exp_t e;
        e.g = g; e.data = d; e.status = s; e.lat = lat;
        rsp_q.push_back(e);
    endtask

    // Target: acks ack_delay cycles after the first WAIT_ACK cycle; negative delay means never
    initial begin : target
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (tgt_cnt == 0) begin
                bus_ack = 1'b1;
                bus_rdata = tgt_rdata;
            end
            if (tgt_cnt >= 0) tgt_cnt--;
            if ((bus_write || bus_read) && ack_delay >= 0) tgt_cnt = ack_delay;
            if (late_ack_cnt != late_seen) begin
                late_seen = late_ack_cnt;
                bus_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        rsp_exp_t e;
        bus_exp_t b;
        rsp_ready = 2'b00;
        forever begin
            @(negedge clk);
            rsp_ready = 2'b00;
            if (rst_cnt != rst_seen) begin
                rst_seen = rst_cnt;
                strobe_open = 1'b0;
            end
            for (int i = 0; i < 2; i++) if (req_ready[i]) rdy_cyc[i] = cyc;
            if (bus_write || bus_read) begin
                check("strobe_before_respond", 32'(strobe_open), 32'h0);
                strobe_open = 1'b1;
                if (bus_q.size() == 0) begin
                    check("unexpected_strobe", {30'h0, bus_write, bus_read}, 32'h0);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_write", 32'(bus_write), 32'(b.wr));
                    check("bus_read", 32'(bus_read), 32'(!b.wr));
                    check("bus_addr", 32'(bus_addr), 32'(b.addr));
                    if (b.wr) check("bus_wdata", bus_wdata, b.wdata);
                end
            end
            if (rsp_valid != 2'b00) begin
                strobe_open = 1'b0;
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), (e.g == 1) ? 32'h2 : 32'h1);
                    check("grant_id", 32'(grant_id), 32'(e.g));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_status", rsp_status, e.status);
                    if (e.lat >= 0) check("rsp_latency", 32'(cyc - rdy_cyc[e.g]), 32'(e.lat));
                    for (int k = 0; k < rsp_delay; k++) begin
                        @(negedge clk);
                        check("rsp_hold_valid", 32'(rsp_valid), (e.g == 1) ? 32'h2 : 32'h1);
                        check("rsp_hold_data", rsp_data, e.data);
                    end
                end
                rsp_ready = rsp_valid;
            end
        end
    end

    task automatic wait_ready(input int g);
        int n = 0;
        while (!req_ready[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[g]) check("req_ready_timeout", 32'(req_ready[g]), 32'h1);
    endtask

    task automatic load(input int i, input int j);
        req_cmd[i*8 +: 8]    = p_cmd[i][j];
        req_addr[i*AW +: AW] = p_addr[i][j];
        req_wdata[i*32 +: 32] = p_wd[i][j];
    endtask

    task automatic single(input int g, input logic [7:0] cmd, input logic [7:0] a, input logic [31:0] wd);
        req_cmd[g*8 +: 8]    = cmd;
        req_addr[g*AW +: AW] = a;
        req_wdata[g*32 +: 32] = wd;
        req_valid[g] = 1'b1;
        @(negedge clk);
        wait_ready(g);
        req_valid[g] = 1'b0;
    endtask

    task automatic run_both(input int n);
        int k[2];
        int grants;
        k[0] = 0; k[1] = 0; grants = 0;
        load(0, 0);
        load(1, 0);
        req_valid = 2'b11;
        for (int t = 0; t < 400 && grants < 2*n; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    grants++;
                    k[i]++;
                    if (k[i] < n) load(i, k[i]);
                    else req_valid[i] = 1'b0;
                end
            end
        end
        if (grants < 2*n) check("grant_count", 32'(grants), 32'(2*n));
        req_valid = 2'b00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || rsp_valid != 2'b00) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_rsp_q", 32'(rsp_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        check("drain_bus_q", 32'(bus_q.size()), 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
        check({tag, "_rsp_status"}, rsp_status, 32'h0);
        check({tag, "_bus_addr"}, 32'(bus_addr), 32'h0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        check({tag, "_strobes_gid"}, {29'h0, bus_write, bus_read, grant_id}, 32'h0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1;
        req_valid = 2'b00;
        req_cmd = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // single write, ack after 2 cycles, response held 2 extra cycles
        ack_delay = 2;
        rsp_delay = 2;
        expect_bus(1'b1, 8'h01, 32'd100);
        expect_rsp(0, 32'h0, 32'h0001_0100, 4);
        single(0, 8'h01, 8'h01, 32'd100);
        wait_idle();
        rsp_delay = 0;

        // single read from requester 1, zero-wait target
        ack_delay = 0;
        tgt_rdata = 32'h0000_0064;
        expect_bus(1'b0, 8'h01, 32'h0);
        expect_rsp(1, 32'h0000_0064, 32'h0000_0104, 2);
        single(1, 8'h00, 8'h01, 32'h0);
        wait_idle();

        // contention: both valid for four transactions, order 0,1,0,1
        ack_delay = 1;
        tgt_rdata = 32'hCAFE_0011;
        p_cmd[0][0] = 8'h01; p_addr[0][0] = 8'h10; p_wd[0][0] = 32'hA0A0_0001;
        p_cmd[0][1] = 8'h00; p_addr[0][1] = 8'h11; p_wd[0][1] = 32'h0;
        p_cmd[1][0] = 8'h01; p_addr[1][0] = 8'h20; p_wd[1][0] = 32'hB0B0_0002;
        p_cmd[1][1] = 8'h00; p_addr[1][1] = 8'h21; p_wd[1][1] = 32'h0;
        expect_bus(1'b1, 8'h10, 32'hA0A0_0001);
        expect_bus(1'b1, 8'h20, 32'hB0B0_0002);
        expect_bus(1'b0, 8'h11, 32'h0);
        expect_bus(1'b0, 8'h21, 32'h0);
        expect_rsp(0, 32'h0,         32'h0001_1000, 3);
        expect_rsp(1, 32'h0,         32'h0001_2004, 3);
        expect_rsp(0, 32'hCAFE_0011, 32'h0000_1100, 3);
        expect_rsp(1, 32'hCAFE_0011, 32'h0000_2104, 3);
        run_both(2);
        wait_idle();

        // timeout: target never acks
        ack_delay = -1;
        expect_bus(1'b0, 8'h02, 32'h0);
        expect_rsp(0, 32'h0, 32'h0000_0201, TO + 1);
        single(0, 8'h00, 8'h02, 32'h0);
        wait_idle();
        late_ack_cnt++;
        repeat (4) @(negedge clk);
        check("late_ack_rsp_valid", 32'(rsp_valid), 32'h0);
        check("late_ack_req_ready", 32'(req_ready), 32'h0);

        // illegal command: no strobe, status bit1 and echoed command
        expect_rsp(1, 32'h0, 32'h0005_0306, 1);
        single(1, 8'h05, 8'h03, 32'h0);
        wait_idle();

        // reset while waiting for ack
        ack_delay = -1;
        expect_bus(1'b0, 8'h04, 32'h0);
        req_cmd[7:0] = 8'h00;
        req_addr[AW-1:0] = 8'h04;
        req_valid[0] = 1'b1;
        @(negedge clk);
        wait_ready(0);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rst_cnt++;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);

        // after reset requester 0 wins first even though it won last before reset
        ack_delay = 0;
        p_cmd[0][0] = 8'h01; p_addr[0][0] = 8'h05; p_wd[0][0] = 32'h0000_0055;
        p_cmd[1][0] = 8'h01; p_addr[1][0] = 8'h06; p_wd[1][0] = 32'h0000_0066;
        expect_bus(1'b1, 8'h05, 32'h0000_0055);
        expect_bus(1'b1, 8'h06, 32'h0000_0066);
        expect_rsp(0, 32'h0, 32'h0001_0500, 2);
        expect_rsp(1, 32'h0, 32'h0001_0604, 2);
        run_both(1);
        wait_idle();

`ifdef REG_BUS_ARB_STATS_EN
        // grants since reset: req0 = 1, req1 = 1; bring to 3 and 2
        expect_bus(1'b1, 8'h07, 32'h1);
        expect_rsp(0, 32'h0, 32'h0001_0700, 2);
        single(0, 8'h01, 8'h07, 32'h1);
        wait_idle();
        expect_bus(1'b1, 8'h07, 32'h1);
        expect_rsp(0, 32'h0, 32'h0001_0700, 2);
        single(0, 8'h01, 8'h07, 32'h1);
        wait_idle();
        expect_bus(1'b1, 8'h08, 32'h2);
        expect_rsp(1, 32'h0, 32'h0001_0804, 2);
        single(1, 8'h01, 8'h08, 32'h2);
        wait_idle();
        expect_rsp(0, 32'h0002_0003, 32'h0000_FF00, 1);
        single(0, 8'h00, 8'hFF, 32'h0);
        wait_idle();
        expect_rsp(0, 32'h0, 32'h0001_FF00, 1);
        single(0, 8'h01, 8'hFF, 32'h0);
        wait_idle();
        expect_rsp(0, 32'h0, 32'h0000_FF00, 1);
        single(0, 8'h00, 8'hFF, 32'h0);
        wait_idle();
`else
        // without statistics 8'hFF is an ordinary bus address
        tgt_rdata = 32'h1234_5678;
        expect_bus(1'b0, 8'hFF, 32'h0);
        expect_rsp(0, 32'h1234_5678, 32'h0000_FF00, 2);
        single(0, 8'h00, 8'hFF, 32'h0);
        wait_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
